// File: rtl/bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the digit-count helper used for parameter checks.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  // Smallest digit count whose decimal range covers the largest magnitude.
  function automatic int bcd_digits_for(input int width, input bit is_signed);
    longint unsigned max_v;
    longint unsigned pow_v;
    int              n_v;
    if (is_signed) begin
      max_v = 64'd1 << (width - 32'sd1);
    end else begin
      max_v = (64'd1 << width) - 64'd1;
    end
    pow_v = 64'd1;
    n_v   = 32'sd0;
    while (pow_v <= max_v) begin
      pow_v = pow_v * 64'd10;
      n_v   = n_v + 32'sd1;
    end
    return n_v;
  endfunction

endpackage

// File: rtl/bcd_seq_if.sv
// Start/result bundle between a numeric source and the BCD converter.
interface bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  load;
  logic [WIDTH-1:0]      number;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     blank;
  logic                  negative;

  modport master (
    output load, number,
    input  ready, done, digits, blank, negative
  );

  modport slave (
    input  load, number,
    output ready, done, digits, blank, negative
  );
endinterface

// File: rtl/bcd_seq_digit_adj.sv
// Single-digit double-dabble corrector: a digit of 5 or more gets +3 before doubling.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  // Pre-shift correction keeps the doubled digit inside 0..9 with a carry out.
  always_comb begin
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end
endmodule

// File: rtl/bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock,
// optional two's-complement input, leading-zero flags and a completion strobe.
module bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b0
) (
  input logic      clk,
  input logic      reset,
  bcd_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 32'sd1);
  localparam int AW = DIGITS * 32'sd4;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1'b1);

  if (WIDTH < 32'sd4 || WIDTH > 32'sd32) begin : g_bad_width
    $error("bcd_seq: WIDTH %0d outside 4..32", WIDTH);
  end
  if (DIGITS < bcd_digits_for(WIDTH, SIGNED)) begin : g_bad_digits
    $error("bcd_seq: DIGITS %0d too small for WIDTH %0d", DIGITS, WIDTH);
  end

  bcd_state_e                  state_r, state_nxt_s;
  logic [WIDTH-1:0]            shreg_r, mag_s;
  logic [DIGITS-1:0][3:0]      acc_r, adj_s, digits_r;
  logic [AW:0]                 shl_s;
  logic [CW-1:0]               cnt_r;
  logic                        sign_r, sign_s, zrun_s;
  logic                        ready_r, done_r, negative_r;
  logic [DIGITS-1:0]           blank_r, blank_s;
  logic                        carry_unused_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.din(acc_r[g]), .dout(adj_s[g]));
  end

  // Carry out of the top digit is always zero for a legal DIGITS.
  assign shl_s          = {adj_s, shreg_r[WIDTH-1]};
  assign carry_unused_s = shl_s[AW];

  // Input magnitude and sign; the most negative value maps onto 2^(WIDTH-1).
  always_comb begin
    sign_s = SIGNED && bus.number[WIDTH-1];
    if (sign_s) begin
      mag_s = ~bus.number + WIDTH'(1'b1);
    end else begin
      mag_s = bus.number;
    end
  end

  // Leading-zero flags from the finished accumulator; digit 0 always shows.
  always_comb begin
    blank_s = '0;
    zrun_s  = 1'b1;
    for (int i = DIGITS - 32'sd1; i > 32'sd0; i--) begin
      zrun_s     = zrun_s && (acc_r[i] == 4'd0);
      blank_s[i] = zrun_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.load) state_nxt_s = ST_SHIFT;
        else          state_nxt_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_r == CW'(1'b1)) state_nxt_s = ST_DONE;
        else                    state_nxt_s = ST_SHIFT;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Conversion datapath: capture on accept, then one shift-and-add per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_r <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      sign_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.load) begin
            shreg_r <= mag_s;
            acc_r   <= '0;
            cnt_r   <= CW'(WIDTH);
            sign_r  <= sign_s;
          end
        end
        ST_SHIFT: begin
          shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
          acc_r   <= shl_s[AW-1:0];
          cnt_r   <= cnt_r - CW'(1'b1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered outputs; results only move on completion, ready stays low on the done cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      digits_r   <= '0;
      blank_r    <= BLANK_RST;
      negative_r <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == ST_IDLE) && (state_r != ST_DONE);
      done_r  <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        digits_r   <= acc_r;
        blank_r    <= blank_s;
        negative_r <= sign_r;
      end
    end
  end

  assign bus.ready    = ready_r;
  assign bus.done     = done_r;
  assign bus.digits   = digits_r;
  assign bus.blank    = blank_r;
  assign bus.negative = negative_r;
endmodule

// File: tb/tb_bcd_seq.sv
// Bench for bcd_seq: a 16-bit unsigned and an 8-bit signed instance checked every
// cycle against a decimal-arithmetic model, with literal pins on chosen results.
module tb_bcd_seq;
  localparam int W_OF [2] = '{16, 8};
  localparam int D_OF [2] = '{5, 3};
  localparam bit SG_OF [2] = '{1'b0, 1'b1};

  logic clk;
  logic reset;

  bcd_seq_if #(.WIDTH(16), .DIGITS(5)) if16 ();
  bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if8 ();

  bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));
  bcd_seq #(.WIDTH(8),  .DIGITS(3), .SIGNED(1'b1)) u_dut8  (.clk(clk), .reset(reset), .bus(if8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Uniform views of both instances
  logic              o_ready [2];
  logic              o_done  [2];
  logic [19:0]       o_dig   [2];
  logic [4:0]        o_blank [2];
  logic              o_neg   [2];
  logic              ld_w    [2];
  longint unsigned   n_w     [2];

  assign o_ready[0] = if16.ready;            assign o_ready[1] = if8.ready;
  assign o_done[0]  = if16.done;             assign o_done[1]  = if8.done;
  assign o_dig[0]   = if16.digits;           assign o_dig[1]   = {8'h00, if8.digits};
  assign o_blank[0] = if16.blank;            assign o_blank[1] = {2'b00, if8.blank};
  assign o_neg[0]   = if16.negative;         assign o_neg[1]   = if8.negative;
  assign ld_w[0]    = if16.load;             assign ld_w[1]    = if8.load;
  assign n_w[0]     = 64'(if16.number);      assign n_w[1]     = 64'(if8.number);

  function automatic longint unsigned mag_of(input longint unsigned n, input int w, input bit sg);
    if (sg && n >= (64'd1 << (w - 1))) return (64'd1 << w) - n;
    return n;
  endfunction

  function automatic logic [19:0] to_bcd(input longint unsigned v);
    logic [19:0]     r;
    longint unsigned t;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] blank_of(input logic [19:0] bcd, input int nd);
    logic [4:0] r;
    bit         z;
    r = 5'b0;
    z = 1'b1;
    for (int i = nd - 1; i >= 1; i--) begin
      z = z && (bcd[i*4 +: 4] == 4'd0);
      r[i] = z;
    end
    return r;
  endfunction

  // Behavioural model: accept when idle, results W+1 edges later, idle again one edge after.
  int              ph     [2];
  longint unsigned cap    [2];
  logic            e_ready[2];
  logic            e_done [2];
  logic [19:0]     e_dig  [2];
  logic [4:0]      e_blank[2];
  logic            e_neg  [2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        ph[d]      <= 0;
        cap[d]     <= 0;
        e_ready[d] <= 1'b1;
        e_done[d]  <= 1'b0;
        e_dig[d]   <= 20'h0;
        e_blank[d] <= blank_of(20'h0, D_OF[d]);
        e_neg[d]   <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (ph[d] == 0) begin
          e_done[d] <= 1'b0;
          if (ld_w[d]) begin
            ph[d]      <= 1;
            cap[d]     <= n_w[d];
            e_ready[d] <= 1'b0;
          end else begin
            e_ready[d] <= 1'b1;
          end
        end else if (ph[d] == W_OF[d] + 1) begin
          ph[d]      <= 0;
          e_done[d]  <= 1'b1;
          e_ready[d] <= 1'b0;
          e_dig[d]   <= to_bcd(mag_of(cap[d], W_OF[d], SG_OF[d]));
          e_blank[d] <= blank_of(to_bcd(mag_of(cap[d], W_OF[d], SG_OF[d])), D_OF[d]);
          e_neg[d]   <= SG_OF[d] && (cap[d] >= (64'd1 << (W_OF[d] - 1)));
        end else begin
          ph[d]      <= ph[d] + 1;
          e_done[d]  <= 1'b0;
          e_ready[d] <= 1'b0;
        end
      end
    end
  end

  // Literal pins posted by the stimulus, consumed by the compare process
  int          pin_seq  [2] = '{0, 0};
  logic [19:0] pin_dig  [2];
  logic [4:0]  pin_blank[2];
  logic        pin_neg  [2];
  int          pin_lat  [2];
  int          to_cnt  = 0;
  bit          held    = 1'b0;
  bit          end_req = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: model check every cycle, plus reset, pin, latency and period checks.
  int pin_used [2] = '{0, 0};
  bit pin_rdy  [2] = '{1'b0, 1'b0};
  int acc_cyc  [2] = '{0, 0};
  int cyc = 0;
  int prev_cyc = 0;
  bit prev_held = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("rst_ready16",  64'(if16.ready),    64'h1);
      chk("rst_done16",   64'(if16.done),     64'h0);
      chk("rst_digits16", 64'(if16.digits),   64'h0);
      chk("rst_blank16",  64'(if16.blank),    64'h1e);
      chk("rst_neg16",    64'(if16.negative), 64'h0);
      chk("rst_blank8",   64'(if8.blank),     64'h6);
      chk("rst_ready8",   64'(if8.ready),     64'h1);
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ready[%0d]", d),  64'(o_ready[d]), 64'(e_ready[d]));
      chk($sformatf("done[%0d]", d),   64'(o_done[d]),  64'(e_done[d]));
      chk($sformatf("digits[%0d]", d), 64'(o_dig[d]),   64'(e_dig[d]));
      chk($sformatf("blank[%0d]", d),  64'(o_blank[d]), 64'(e_blank[d]));
      chk($sformatf("neg[%0d]", d),    64'(o_neg[d]),   64'(e_neg[d]));
      if (pin_rdy[d]) begin
        chk($sformatf("ready_after_done[%0d]", d), 64'(o_ready[d]), 64'h1);
        pin_rdy[d] = 1'b0;
      end
      if (o_done[d] && pin_seq[d] != pin_used[d]) begin
        pin_used[d] = pin_seq[d];
        chk($sformatf("pin_digits[%0d]", d),       64'(o_dig[d]),   64'(pin_dig[d]));
        chk($sformatf("pin_model_digits[%0d]", d), 64'(e_dig[d]),   64'(pin_dig[d]));
        chk($sformatf("pin_blank[%0d]", d),        64'(o_blank[d]), 64'(pin_blank[d]));
        chk($sformatf("pin_model_blank[%0d]", d),  64'(e_blank[d]), 64'(pin_blank[d]));
        chk($sformatf("pin_neg[%0d]", d),          64'(o_neg[d]),   64'(pin_neg[d]));
        chk($sformatf("pin_latency[%0d]", d),      64'(cyc - acc_cyc[d]), 64'(pin_lat[d]));
        pin_rdy[d] = 1'b1;
      end
      if (reset && ld_w[d] && o_ready[d]) acc_cyc[d] = cyc + 1;
    end
    if (if16.done) begin
      if (held && prev_held) chk("held_period16", 64'(cyc - prev_cyc), 64'd18);
      prev_cyc  = cyc;
      prev_held = held;
    end
    if (end_req) begin
      chk("timeouts", 64'(to_cnt), 64'h0);
      chk("pins_done16", 64'(pin_used[0]), 64'(pin_seq[0]));
      chk("pins_done8",  64'(pin_used[1]), 64'(pin_seq[1]));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic ld, input longint unsigned n);
    if (d == 0) begin
      if16.load   = ld;
      if16.number = 16'(n);
    end else begin
      if8.load   = ld;
      if8.number = 8'(n);
    end
  endtask

  task automatic wait_rdy(input int d);
    int k;
    k = 0;
    while (!o_ready[d] && k < 60) begin
      step();
      k++;
    end
    if (!o_ready[d]) to_cnt++;
  endtask

  task automatic arm(input int d, input logic [19:0] dg, input logic [4:0] bl, input logic ng);
    pin_dig[d]   = dg;
    pin_blank[d] = bl;
    pin_neg[d]   = ng;
    pin_lat[d]   = W_OF[d] + 1;
    pin_seq[d]++;
  endtask

  task automatic start(input int d, input longint unsigned n);
    wait_rdy(d);
    drive(d, 1'b1, n);
    step();
    drive(d, 1'b0, n);
  endtask

  task automatic conv(input int d, input longint unsigned n, input logic [19:0] dg,
                      input logic [4:0] bl, input logic ng);
    arm(d, dg, bl, ng);
    start(d, n);
    repeat (W_OF[d] + 2) step();
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    #1 reset = 1'b0;
    repeat (3) step();
    // Load presented together with reset release
    reset = 1'b1;
    conv(0, 12345, 20'h12345, 5'b00000, 1'b0);
    conv(0, 0,     20'h00000, 5'b11110, 1'b0);
    conv(0, 65535, 20'h65535, 5'b00000, 1'b0);
    conv(0, 100,   20'h00100, 5'b11000, 1'b0);
    conv(0, 9,     20'h00009, 5'b11110, 1'b0);
    conv(1, 8'h80, 20'h00128, 5'b00000, 1'b1);
    conv(1, 8'hFF, 20'h00001, 5'b00110, 1'b1);
    conv(1, 127,   20'h00127, 5'b00000, 1'b0);
    conv(1, 0,     20'h00000, 5'b00110, 1'b0);
    conv(1, 8'h9C, 20'h00100, 5'b00000, 1'b1);
    // Load during a conversion is ignored
    arm(0, 20'h00042, 5'b11100, 1'b0);
    start(0, 42);
    repeat (4) step();
    drive(0, 1'b1, 999);
    step();
    drive(0, 1'b0, 999);
    repeat (W_OF[0] + 6) step();
    // Reset in the middle of a conversion, then a fresh one right at release
    start(0, 54321);
    repeat (7) step();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    conv(0, 7, 20'h00007, 5'b11110, 1'b0);
    // Load held high with a stepping value
    wait_rdy(0);
    held = 1'b1;
    for (int k = 0; k < 72; k++) begin
      drive(0, 1'b1, k % 21);
      step();
    end
    held = 1'b0;
    drive(0, 1'b0, 0);
    repeat (20) step();
    end_req = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, vectors %0d miscompares %0d", n_vec, n_fail);
    $fatal(1);
  end
endmodule
